alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Command-side initiator for the 2-bit ALU (ALU_2bit). Accepts operation commands on a
//  valid/ready port and translates cmd_op into alu_op/functop. Drives operands and holds
//  them stable for a settle window. Captures result/carry/borrow and returns them on a
//  valid/ready response port. Sits between the instruction/control path and the ALU.
// PARAMETERS
//  SETTLE_CYC  1  cycles ALU inputs are held before capture (legal 1..15)
//  CNT_W       4  width of the completed-operation counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, asynchronous, active-high
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      block can accept a command
//  cmd_op      in   2      00 ADD, 01 SUB, 10 AND, 11 OR
//  cmd_a       in   2      operand a
//  cmd_b       in   2      operand b
//  alu_a       out  2      to ALU a
//  alu_b       out  2      to ALU b
//  alu_op      out  1      to ALU alu_op
//  functop     out  5      to ALU functop
//  alu_result  in   2      from ALU result
//  alu_carry   in   1      from ALU carry_out
//  alu_borrow  in   1      from ALU borrow_out
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      consumer accepts response
//  rsp_result  out  2      captured result
//  rsp_carry   out  1      captured carry (ADD only, else 0)
//  rsp_borrow  out  1      captured borrow (SUB only, else 0)
//  op_count    out  CNT_W  completed responses, wraps
// BEHAVIOUR
//  - FSM states: IDLE, DRIVE, RESP. Reset state is IDLE.
//  - Reset values: all registered outputs 0. alu_op=0, functop=00000, rsp_valid=0, op_count=0.
//  - cmd_ready = (state==IDLE) & ~rst. It is combinational and low in DRIVE/RESP.
//  - IDLE: on cmd_valid&cmd_ready, register operands/op, load settle counter with
//    SETTLE_CYC-1, go to DRIVE. Commands offered while not ready are ignored, not queued.
//  - DRIVE: alu_op=1; functop ADD=01000, SUB=00100, AND=00000, OR=11000; alu_a/alu_b hold
//    the registered operands. The counter decrements each cycle. On the edge where it is 0:
//    - capture alu_result into rsp_result;
//    - capture carry masked by op==ADD and borrow masked by op==SUB;
//    - set rsp_valid=1 and go to RESP.
//  - Latency: rsp_valid rises exactly SETTLE_CYC+1 edges after the accept edge.
//  - RESP: alu_op=0, functop=00000, alu_a=alu_b=00. rsp_* are held stable while
//    rsp_valid & ~rsp_ready. On rsp_valid&rsp_ready: clear rsp_valid, op_count+1, go to IDLE.
//  - op_count wraps from 2^CNT_W-1 to 0.
//  - Throughput: at most one op per SETTLE_CYC+2 cycles. No new accept in the handshake cycle.
//  - IDLE drives ALU inputs as in RESP.
//  - Reset mid-operation (DRIVE or RESP) aborts immediately. The FSM returns to IDLE,
//    rsp_valid=0, the in-flight command is lost, and op_count=0.
//  - Arithmetic is done by the ALU. This block does no width extension and passes
//    2-bit values unchanged.
// CONFIGURATION
//  ALU_CHAIN_EN defined:
//    - adds input port cmd_chain (1 bit), sampled at accept;
//    - if 1, alu_a uses the last captured rsp_result (00 after reset) instead of cmd_a.
//  ALU_CHAIN_EN undefined: cmd_chain port is absent and alu_a always comes from cmd_a.
// TESTING (bench instantiates ALU_2bit, SETTLE_CYC=1 unless stated)
//  - ADD a=01 b=01 -> rsp_result=10 carry=0 borrow=0; rsp_valid 2 edges after accept.
//    ADD 11+01 -> 00 carry=1.
//  - SUB a=10 b=01 -> 01 borrow=0. SUB 01-10 -> 11 borrow=1 carry=0.
//  - AND 11&10 -> 10, OR 01|10 -> 11, both flags 0.
//    Check functop 00000/11000 with alu_op=1 in DRIVE, and 0/00000 otherwise.
//  - Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, op_count
//    unchanged. Then release -> op_count+1 and cmd_ready=1 the next cycle.
//  - Reset pulse during DRIVE -> rsp_valid never asserts, op_count=0, cmd_ready=1 after
//    release. Also run 16 ops with CNT_W=4 -> op_count wraps to 0.
//  - SETTLE_CYC=3: latency 4 edges. With ALU_CHAIN_EN: ADD 01+01=10, then chained
//    ADD b=01 -> 11.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-side and response signals for alu_issue_ctrl.
// ALU_CHAIN_EN adds cmd_chain to the command channel.
interface alu_issue_ctrl_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_a;
  logic [1:0]       cmd_b;
`ifdef ALU_CHAIN_EN
  logic             cmd_chain;
`endif
  logic [1:0]       alu_a;
  logic [1:0]       alu_b;
  logic             alu_op;
  logic [4:0]       functop;
  logic [1:0]       alu_result;
  logic             alu_carry;
  logic             alu_borrow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_borrow;
  logic [CNT_W-1:0] op_count;

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_CHAIN_EN
    input  cmd_chain,
`endif
    input  alu_result, alu_carry, alu_borrow, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, functop,
    output rsp_valid, rsp_result, rsp_carry, rsp_borrow, op_count
  );

  // Instruction path / ALU / consumer side.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_CHAIN_EN
    output cmd_chain,
`endif
    output alu_result, alu_carry, alu_borrow, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, functop,
    input  rsp_valid, rsp_result, rsp_carry, rsp_borrow, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to the 2-bit ALU, holds operands for a settle window and
// returns the captured result. Define ALU_CHAIN_EN to feed the last result back as operand a.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 4
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpOr  = 2'b11;
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       a_q, a_d;
  logic [1:0]       b_q, b_d;
  logic [3:0]       settle_q, settle_d;
  logic [1:0]       res_q, res_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign bus.cmd_ready  = (state_q == StIdle) & ~rst;
  assign accept         = bus.cmd_valid & bus.cmd_ready;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_borrow = borrow_q;
  assign bus.op_count   = cnt_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    res_d    = res_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = bus.cmd_op;
`ifdef ALU_CHAIN_EN
          // res_q still holds the last captured result (00 after reset).
          a_d      = bus.cmd_chain ? res_q : bus.cmd_a;
`else
          a_d      = bus.cmd_a;
`endif
          b_d      = bus.cmd_b;
          settle_d = SettleLoad;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (settle_q == 4'd0) begin
          res_d    = bus.alu_result;
          carry_d  = bus.alu_carry & (op_q == OpAdd);
          borrow_d = bus.alu_borrow & (op_q == OpSub);
          valid_d  = 1'b1;
          state_d  = StResp;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU inputs are only live while driving; parked at zero otherwise.
  always_comb begin
    bus.alu_op  = 1'b0;
    bus.functop = 5'b00000;
    bus.alu_a   = 2'b00;
    bus.alu_b   = 2'b00;
    if (state_q == StDrive) begin
      bus.alu_op = 1'b1;
      bus.alu_a  = a_q;
      bus.alu_b  = b_q;
      unique case (op_q)
        OpAdd: bus.functop = 5'b01000;
        OpSub: bus.functop = 5'b00100;
        OpAnd: bus.functop = 5'b00000;
        OpOr:  bus.functop = 5'b11000;
        default: bus.functop = 5'b00000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      a_q      <= 2'b00;
      b_q      <= 2'b00;
      settle_q <= 4'd0;
      res_q    <= 2'b00;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: two instances (SETTLE_CYC 1 and 3) share stimulus,
// each talks to a behavioural 2-bit ALU, results are compared with a reference model.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00, cmd_a = 2'b00, cmd_b = 2'b00;
  logic       cmd_chain = 1'b0;
  logic       rsp_ready = 1'b1;

  alu_issue_ctrl_if #(.CNT_W(4)) bus1 ();
  alu_issue_ctrl_if #(.CNT_W(4)) bus3 ();

  alu_issue_ctrl #(.SETTLE_CYC(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_issue_ctrl #(.SETTLE_CYC(3), .CNT_W(4)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Behavioural ALU: flags always reflect a+b / a-b so the controller's masking matters.
  function automatic logic [3:0] alu_fn(input logic aop, input logic [4:0] fop,
                                        input logic [1:0] a, input logic [1:0] b);
    int s;
    logic [1:0] r;
    logic c, bo;
    if (!aop) return 4'b0000;
    s  = int'(a) + int'(b);
    c  = (s > 3);
    bo = (a < b);
    case (fop)
      5'b01000: r = 2'(s);
      5'b00100: r = a - b;
      5'b00000: r = a & b;
      5'b11000: r = a | b;
      default:  r = 2'b00;
    endcase
    return {r, c, bo};
  endfunction

  assign bus1.cmd_valid = cmd_valid;
  assign bus1.cmd_op    = cmd_op;
  assign bus1.cmd_a     = cmd_a;
  assign bus1.cmd_b     = cmd_b;
  assign bus1.rsp_ready = rsp_ready;
  assign {bus1.alu_result, bus1.alu_carry, bus1.alu_borrow} =
      alu_fn(bus1.alu_op, bus1.functop, bus1.alu_a, bus1.alu_b);
  assign bus3.cmd_valid = cmd_valid;
  assign bus3.cmd_op    = cmd_op;
  assign bus3.cmd_a     = cmd_a;
  assign bus3.cmd_b     = cmd_b;
  assign bus3.rsp_ready = rsp_ready;
  assign {bus3.alu_result, bus3.alu_carry, bus3.alu_borrow} =
      alu_fn(bus3.alu_op, bus3.functop, bus3.alu_a, bus3.alu_b);
`ifdef ALU_CHAIN_EN
  assign bus1.cmd_chain = cmd_chain;
  assign bus3.cmd_chain = cmd_chain;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [4:0] ftab [4] = '{5'b01000, 5'b00100, 5'b00000, 5'b11000};
  int settle [2] = '{1, 3};
  int phase [2];
  int cnt_exp [2] = '{0, 0};
  int last_res = 0;
  int cur_op, cur_a, cur_b, cur_res;
  logic cur_c, cur_bo;

  function automatic logic [3:0] ref_op(input int op, input int a, input int b);
    int r;
    logic c, bo;
    c  = 1'b0;
    bo = 1'b0;
    case (op)
      0:       begin r = (a + b) % 4; c = (a + b) > 3; end
      1:       begin r = (a - b + 4) % 4; bo = (a < b); end
      2:       r = a & b;
      default: r = a | b;
    endcase
    return {2'(r), c, bo};
  endfunction

  // Called once per negedge after the accept edge; t counts edges including the accept edge.
  task automatic obs(input int id, input int t, input logic rdy, input logic rv, input logic cr,
                     input logic aop, input logic [4:0] fop, input logic [1:0] aa,
                     input logic [1:0] ab, input logic [1:0] res, input logic car,
                     input logic bor, input logic [3:0] cnt);
    string p;
    p = (id == 0) ? "s1" : "s3";
    case (phase[id])
      0: begin
        if (rv) begin
          check({p, ".latency"}, t, settle[id] + 1);
          check({p, ".result"}, res, cur_res);
          check({p, ".carry"}, car, cur_c);
          check({p, ".borrow"}, bor, cur_bo);
          check({p, ".ready_in_resp"}, cr, 0);
          phase[id] = 1;
        end else begin
          check({p, ".drive_alu_op"}, aop, 1);
          check({p, ".drive_functop"}, fop, ftab[cur_op]);
          check({p, ".drive_a"}, aa, cur_a);
          check({p, ".drive_b"}, ab, cur_b);
          check({p, ".ready_in_drive"}, cr, 0);
        end
      end
      1: begin
        if (rdy) begin
          cnt_exp[id] = (cnt_exp[id] + 1) % 16;
          check({p, ".valid_cleared"}, rv, 0);
          check({p, ".ready_after_hs"}, cr, 1);
          check({p, ".op_count"}, cnt, cnt_exp[id]);
          phase[id] = 2;
        end else begin
          check({p, ".hold_valid"}, rv, 1);
          check({p, ".hold_result"}, res, cur_res);
          check({p, ".hold_flags"}, {car, bor}, {cur_c, cur_bo});
          check({p, ".hold_ready"}, cr, 0);
          check({p, ".hold_count"}, cnt, cnt_exp[id]);
          check({p, ".resp_alu"}, {aop, fop, aa, ab}, 0);
        end
      end
      default: begin
        check({p, ".idle_alu"}, {aop, fop, aa, ab}, 0);
        check({p, ".idle_ready"}, cr, 1);
      end
    endcase
  endtask

  // Entered and left at a negedge with both instances idle.
  task automatic do_op(input int op, input int a, input int b, input int chain, input int hold);
    logic [3:0] r;
    logic rdy;
    bit done;
    cur_op  = op;
    cur_a   = chain ? last_res : a;
    cur_b   = b;
    r       = ref_op(cur_op, cur_a, cur_b);
    cur_res = int'(r[3:2]);
    cur_c   = r[1];
    cur_bo  = r[0];
    check("s1.ready_before", bus1.cmd_ready, 1);
    check("s3.ready_before", bus3.cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_a     = 2'(a);
    cmd_b     = 2'(b);
    cmd_chain = chain[0];
    rsp_ready = (hold == 0);
    phase     = '{0, 0};
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    done = 1'b0;
    for (int t = 1; t <= 40 && !done; t++) begin
      rdy = rsp_ready;
      obs(0, t, rdy, bus1.rsp_valid, bus1.cmd_ready, bus1.alu_op, bus1.functop, bus1.alu_a,
          bus1.alu_b, bus1.rsp_result, bus1.rsp_carry, bus1.rsp_borrow, bus1.op_count);
      obs(1, t, rdy, bus3.rsp_valid, bus3.cmd_ready, bus3.alu_op, bus3.functop, bus3.alu_a,
          bus3.alu_b, bus3.rsp_result, bus3.rsp_carry, bus3.rsp_borrow, bus3.op_count);
      if (t >= hold) rsp_ready = 1'b1;
      done = (phase[0] == 2) && (phase[1] == 2);
      @(negedge clk);
    end
    check("op_completed", done, 1);
    last_res = cur_res;
  endtask

  task automatic reset_mid_op();
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_a     = 2'b01;
    cmd_b     = 2'b01;
    cmd_chain = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst.s1_in_drive", bus1.alu_op, 1);
    check("rst.s3_in_drive", bus3.alu_op, 1);
    rst = 1'b1;
    #1;
    check("rst.valid", {bus1.rsp_valid, bus3.rsp_valid}, 0);
    check("rst.count", {bus1.op_count, bus3.op_count}, 0);
    check("rst.ready_low", {bus1.cmd_ready, bus3.cmd_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.ready_after", {bus1.cmd_ready, bus3.cmd_ready}, 2'b11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst.no_valid", {bus1.rsp_valid, bus3.rsp_valid}, 0);
    end
    cnt_exp  = '{0, 0};
    last_res = 0;
  endtask

  initial begin
    #2;
    check("reset.ready", {bus1.cmd_ready, bus3.cmd_ready}, 0);
    check("reset.valid", {bus1.rsp_valid, bus3.rsp_valid}, 0);
    check("reset.count", {bus1.op_count, bus3.op_count}, 0);
    check("reset.alu_op", {bus1.alu_op, bus3.alu_op}, 0);
    check("reset.functop", {bus1.functop, bus3.functop}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("release.ready", {bus1.cmd_ready, bus3.cmd_ready}, 2'b11);
    @(negedge clk);

    do_op(0, 1, 1, 0, 0);
    do_op(0, 3, 1, 0, 0);
    do_op(1, 2, 1, 0, 0);
    do_op(1, 1, 2, 0, 0);
    do_op(2, 3, 2, 0, 0);
    do_op(3, 1, 2, 0, 0);
    do_op(0, 2, 3, 0, 10);
`ifdef ALU_CHAIN_EN
    do_op(0, 1, 1, 0, 0);
    do_op(0, 2, 1, 1, 0);
    check("chain.result", last_res, 3);
`endif

    for (int i = 0; i < 20; i++) begin
      int ch;
      ch = 0;
`ifdef ALU_CHAIN_EN
      ch = int'($urandom_range(0, 1));
`endif
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ch, int'($urandom_range(0, 6)));
    end

    reset_mid_op();
    for (int i = 0; i < 16; i++) begin
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            0, int'($urandom_range(0, 2)));
    end
    check("wrap.s1", bus1.op_count, 0);
    check("wrap.s3", bus3.op_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
